key_set_ctrl: RTL and testbench
===============================

// Module: key_set_ctrl
// PURPOSE
//   Time-set sequencer for the seg clock. Consumes two debounced key levels (MODE, INC)
//   and a periodic tick. Steps a RUN/HOUR/MIN/SEC setting state machine and issues
//   one-cycle increment strobes to the time counter. Optional auto-repeat on a held INC.
//   Sits between the key_debounce instances and the hour/min/sec counters.
// PARAMETERS
//   KEY_PRESSED_LVL  1'b0  key level that means "pressed"
//   LONG_TICKS       500   i_tick count INC must be held before the first repeat strobe
//   REPEAT_TICKS     100   i_tick count between later repeat strobes
//   TIMEOUT_TICKS    10000 idle i_tick count in a set state before forced return to RUN; 0 = never
// PORTS
//   i_clk        in   1  system clock, all logic on posedge
//   i_reset_n    in   1  asynchronous active-low reset
//   i_tick       in   1  one-cycle strobe, e.g. 1 kHz; all hold/idle timing counts it
//   i_key_mode   in   1  debounced MODE key level
//   i_key_inc    in   1  debounced INC key level
//   o_mode       out  2  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   o_run_en     out  1  1 only in RUN; time counter advances only when high
//   o_inc_hour   out  1  one-cycle increment strobe, hour field
//   o_inc_min    out  1  one-cycle increment strobe, minute field
//   o_inc_sec    out  1  one-cycle increment strobe, second field
//   o_timeout    out  1  one-cycle strobe when the idle timeout forces RUN
// BEHAVIOUR
//   Reset: o_mode=0, o_run_en=1, all strobes 0. Previous-level regs=0. Hold and idle counters=0.
//   Press edge: key sampled != KEY_PRESSED_LVL in the previous cycle, == KEY_PRESSED_LVL now.
//     The previous-level reg resets to 0. With KEY_PRESSED_LVL=0, a key held low through
//     reset gives no edge until it is released and pressed again.
//   Latency: an edge sampled at clock edge N updates o_mode or drives a strobe from edge N.
//     The strobe is visible for exactly one cycle.
//   FSM on MODE press edge: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
//     o_run_en = (o_mode==0), registered.
//   INC press edge in SET_x: pulse o_inc_x. INC in RUN is ignored: no strobe, no state change.
//   MODE and INC edges in the same cycle: MODE wins, the INC edge is dropped.
//   At most one o_inc_* high in any cycle. Strobes never assert in RUN.
//   Idle counter: active only in SET states and counts i_tick. It clears on any press edge,
//     any repeat strobe, and on entry into a SET state. When count reaches TIMEOUT_TICKS:
//     o_mode<=0, o_timeout pulses 1 cycle, and any repeat is cancelled.
//     If a MODE edge occurs in the same cycle, the MODE edge applies and there is no timeout strobe.
//   Counter widths are $clog2(max+1). Counters saturate and never wrap.
//   Asynchronous reset mid-hold or mid-set: immediate return to reset values.
//     After release, a new press edge is needed.
// CONFIGURATION
//   KEY_AUTO_REPEAT_EN defined:
//     - An INC press edge in SET_x arms repeat. The hold counter counts i_tick while INC stays pressed.
//     - When the count reaches LONG_TICKS: strobe, counter clears, then a strobe every REPEAT_TICKS.
//     - INC release, any MODE edge, or a timeout disarms repeat and clears the counter.
//     - A held INC carried into a new state does not repeat until it is released and pressed again.
//   KEY_AUTO_REPEAT_EN undefined:
//     - Hold counter and repeat logic are absent.
//     - Exactly one strobe per INC press edge.
// TESTING  (LONG_TICKS=4, REPEAT_TICKS=2, TIMEOUT_TICKS=10, i_tick every 4 clk)
//   1. Reset, then 4 MODE presses: o_mode 0->1->2->3->0. o_run_en 1,0,0,0,1.
//      Each change lands 1 clk after the sampled edge.
//   2. SET_MIN, 3 INC presses: exactly 3 one-cycle o_inc_min strobes.
//      o_inc_hour and o_inc_sec stay 0. INC presses in RUN give no strobe.
//   3. MODE and INC press edges in the same clk while in SET_HOUR: o_mode->2, no o_inc_hour strobe.
//   4. SET_SEC with no keys for 10 ticks: o_mode->0, o_timeout high 1 clk.
//      An INC press at tick 9 restarts the count, so timeout comes 10 ticks after that press.
//   5. KEY_AUTO_REPEAT_EN, SET_HOUR, INC held 12 ticks: strobes at press, +4, +6, +8, +10, +12 ticks.
//      Without the macro: 1 strobe only.
//   6. Assert i_reset_n=0 mid-repeat: outputs go to reset values at once.
//      INC still held after release gives no strobe.

Source files
------------

// File: rtl/key_set_ctrl.sv
// key_set_ctrl
//   Time-set sequencer for the seg clock. Two debounced key levels (MODE, INC)
//   and a periodic tick drive a RUN / SET_HOUR / SET_MIN / SET_SEC state machine
//   that issues one-cycle increment strobes to the hour/min/sec counters.
//   An idle timeout returns a set state to RUN.
//
//   Optional feature: define KEY_AUTO_REPEAT_EN to enable auto-repeat on a held
//   INC key (first repeat after LONG_TICKS ticks, then every REPEAT_TICKS ticks).
//   LONG_TICKS and REPEAT_TICKS must be at least 1. TIMEOUT_TICKS = 0 disables
//   the idle timeout.
//
// Ports
//   i_clk       in   system clock, all logic on posedge
//   i_reset_n   in   asynchronous active-low reset
//   i_tick      in   one-cycle timing strobe; hold and idle timing count it
//   i_key_mode  in   debounced MODE key level
//   i_key_inc   in   debounced INC key level
//   o_mode      out  current state: 0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   o_run_en    out  high only in RUN
//   o_inc_hour  out  one-cycle increment strobe, hour field
//   o_inc_min   out  one-cycle increment strobe, minute field
//   o_inc_sec   out  one-cycle increment strobe, second field
//   o_timeout   out  one-cycle strobe when the idle timeout forces RUN
//
// o_mode is the state register itself, so it doubles as the FSM debug view.
module key_set_ctrl #(
   parameter logic        KEY_PRESSED_LVL = 1'b0,
   parameter int unsigned LONG_TICKS      = 500,
   parameter int unsigned REPEAT_TICKS    = 100,
   parameter int unsigned TIMEOUT_TICKS   = 10000
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_tick,
   input  logic       i_key_mode,
   input  logic       i_key_inc,
   output logic [1:0] o_mode,
   output logic       o_run_en,
   output logic       o_inc_hour,
   output logic       o_inc_min,
   output logic       o_inc_sec,
   output logic       o_timeout
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_SEC  = 2'd3
   } state_t;

   localparam int unsigned        IDLE_W    = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
   localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(TIMEOUT_TICKS);
   localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);

   state_t              state_q, state_d;
   logic                mode_prev_q, inc_prev_q;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic                run_en_q, inc_hour_q, inc_min_q, inc_sec_q, timeout_q;

   logic                mode_edge, inc_edge, in_set;
   logic                timeout_hit, inc_accept, rpt_fire, rpt_strobe, inc_strobe;

   // Previous-level regs reset to 0; with an active-low key this means a key
   // held through reset is treated as already pressed and gives no edge.
   assign mode_edge = (mode_prev_q != KEY_PRESSED_LVL) && (i_key_mode == KEY_PRESSED_LVL);
   assign inc_edge  = (inc_prev_q  != KEY_PRESSED_LVL) && (i_key_inc  == KEY_PRESSED_LVL);
   assign in_set    = (state_q != ST_RUN);

   // The timeout fires on the tick that brings the idle count to TIMEOUT_TICKS.
   // A MODE edge in the same cycle takes precedence; an INC edge does not.
   assign timeout_hit = (TIMEOUT_TICKS != 0) && in_set && i_tick &&
                        (idle_q == IDLE_LAST) && !mode_edge;
   assign inc_accept  = in_set && inc_edge && !mode_edge && !timeout_hit;
   assign rpt_strobe  = rpt_fire && !mode_edge && !timeout_hit && !inc_accept;
   assign inc_strobe  = inc_accept || rpt_strobe;

   always_comb begin
      state_d = state_q;
      if (mode_edge) begin
         case (state_q)
            ST_RUN:      state_d = ST_SET_HOUR;
            ST_SET_HOUR: state_d = ST_SET_MIN;
            ST_SET_MIN:  state_d = ST_SET_SEC;
            default:     state_d = ST_RUN;
         endcase
      end else if (timeout_hit) begin
         state_d = ST_RUN;
      end
   end

   // Idle counter: runs only in set states; any activity restarts it.
   always_comb begin
      idle_d = idle_q;
      if (!in_set || mode_edge || inc_edge || rpt_fire || timeout_hit) begin
         idle_d = '0;
      end else if (i_tick && (idle_q != IDLE_MAX)) begin
         idle_d = idle_q + 1'b1;
      end
   end

`ifdef KEY_AUTO_REPEAT_EN
   localparam int unsigned        HOLD_TOP  = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int unsigned        HOLD_W    = $clog2(HOLD_TOP + 1);
   localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_TOP);
   localparam logic [HOLD_W-1:0]  LONG_LAST = HOLD_W'(LONG_TICKS - 1);
   localparam logic [HOLD_W-1:0]  REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);

   logic                inc_pressed;
   logic                rpt_armed_q, rpt_armed_d;
   logic                rpt_first_q, rpt_first_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;

   assign inc_pressed = (i_key_inc == KEY_PRESSED_LVL);
   // rpt_first selects the long initial delay versus the shorter repeat period.
   assign rpt_fire    = rpt_armed_q && inc_pressed && i_tick &&
                        (hold_q == (rpt_first_q ? LONG_LAST : REP_LAST));

   always_comb begin
      rpt_armed_d = rpt_armed_q;
      rpt_first_d = rpt_first_q;
      hold_d      = hold_q;
      if (mode_edge || timeout_hit || !inc_pressed) begin
         rpt_armed_d = 1'b0;
         rpt_first_d = 1'b1;
         hold_d      = '0;
      end else if (inc_accept) begin
         rpt_armed_d = 1'b1;
         rpt_first_d = 1'b1;
         hold_d      = '0;
      end else if (rpt_strobe) begin
         rpt_first_d = 1'b0;
         hold_d      = '0;
      end else if (rpt_armed_q && i_tick && (hold_q != HOLD_MAX)) begin
         hold_d = hold_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rpt_armed_q <= 1'b0;
         rpt_first_q <= 1'b1;
         hold_q      <= '0;
      end else begin
         rpt_armed_q <= rpt_armed_d;
         rpt_first_q <= rpt_first_d;
         hold_q      <= hold_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_RUN;
         mode_prev_q <= 1'b0;
         inc_prev_q  <= 1'b0;
         idle_q      <= '0;
         run_en_q    <= 1'b1;
         inc_hour_q  <= 1'b0;
         inc_min_q   <= 1'b0;
         inc_sec_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_prev_q <= i_key_mode;
         inc_prev_q  <= i_key_inc;
         idle_q      <= idle_d;
         run_en_q    <= (state_d == ST_RUN);
         // A strobe never coincides with a state change, so state_q names the field.
         inc_hour_q  <= inc_strobe && (state_q == ST_SET_HOUR);
         inc_min_q   <= inc_strobe && (state_q == ST_SET_MIN);
         inc_sec_q   <= inc_strobe && (state_q == ST_SET_SEC);
         timeout_q   <= timeout_hit;
      end
   end

   assign o_mode     = state_q;
   assign o_run_en   = run_en_q;
   assign o_inc_hour = inc_hour_q;
   assign o_inc_min  = inc_min_q;
   assign o_inc_sec  = inc_sec_q;
   assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_key_set_ctrl.sv
// Directed bench for key_set_ctrl with LONG_TICKS=4, REPEAT_TICKS=2,
// TIMEOUT_TICKS=10 and i_tick every 4 clocks. Inputs change on the falling
// edge; outputs are read on the falling edge after the sampling rising edge.
module tb_key_set_ctrl;

   logic       i_clk;
   logic       i_reset_n;
   logic       i_tick;
   logic       i_key_mode;
   logic       i_key_inc;
   logic [1:0] o_mode;
   logic       o_run_en;
   logic       o_inc_hour;
   logic       o_inc_min;
   logic       o_inc_sec;
   logic       o_timeout;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int n_hour = 0, n_min = 0, n_sec = 0, n_timeout = 0;
   int n_multi = 0, n_run_strobe = 0;

   key_set_ctrl #(
      .KEY_PRESSED_LVL (1'b0),
      .LONG_TICKS      (4),
      .REPEAT_TICKS    (2),
      .TIMEOUT_TICKS   (10)
   ) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_tick     (i_tick),
      .i_key_mode (i_key_mode),
      .i_key_inc  (i_key_inc),
      .o_mode     (o_mode),
      .o_run_en   (o_run_en),
      .o_inc_hour (o_inc_hour),
      .o_inc_min  (o_inc_min),
      .o_inc_sec  (o_inc_sec),
      .o_timeout  (o_timeout)
   );

   // clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // strobe monitor, sampled 2 time units after each rising edge
   always begin
      @(posedge i_clk);
      #2;
      if (i_reset_n) begin
         if (o_inc_hour) n_hour++;
         if (o_inc_min)  n_min++;
         if (o_inc_sec)  n_sec++;
         if (o_timeout)  n_timeout++;
         if ((32'(o_inc_hour) + 32'(o_inc_min) + 32'(o_inc_sec)) > 1) n_multi++;
         if ((o_mode == 2'd0) && (o_inc_hour || o_inc_min || o_inc_sec)) n_run_strobe++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock; the tick driven here is sampled on the next rising edge
   task automatic step();
      @(negedge i_clk);
      cyc++;
      i_tick = ((cyc % 4) == 0);
   endtask

   task automatic align(input int r);
      while ((cyc % 4) != r) step();
   endtask

   task automatic press_mode(input logic [1:0] exp_mode);
      i_key_mode = 1'b0;
      step();
      check("mode_after_press", 32'(o_mode), 32'(exp_mode));
      check("run_en_after_press", 32'(o_run_en), (exp_mode == 2'd0) ? 1 : 0);
      i_key_mode = 1'b1;
      step();
   endtask

   function automatic logic [31:0] exp_t5(input int r);
`ifdef KEY_AUTO_REPEAT_EN
      return ((r == 1) || (r == 16) || (r == 24) || (r == 32) || (r == 40) || (r == 48)) ? 1 : 0;
`else
      return (r == 1) ? 1 : 0;
`endif
   endfunction

   initial begin
      int c0;
      int hour_snap;
      i_reset_n  = 1'b0;
      i_tick     = 1'b0;
      i_key_mode = 1'b1;
      i_key_inc  = 1'b1;

      // reset
      repeat (3) step();
      check("rst_mode", 32'(o_mode), 0);
      check("rst_run_en", 32'(o_run_en), 1);
      check("rst_strobes", 32'({o_inc_hour, o_inc_min, o_inc_sec, o_timeout}), 0);
      i_reset_n = 1'b1;
      repeat (2) step();
      check("post_rst_mode", 32'(o_mode), 0);

      // 1: MODE cycles RUN -> HOUR -> MIN -> SEC -> RUN
      press_mode(2'd1);
      press_mode(2'd2);
      press_mode(2'd3);
      press_mode(2'd0);

      // 2: INC in RUN is ignored
      i_key_inc = 1'b0;
      step();
      check("run_inc_strobes", 32'({o_inc_hour, o_inc_min, o_inc_sec}), 0);
      check("run_inc_mode", 32'(o_mode), 0);
      i_key_inc = 1'b1;
      step();
      check("run_inc_strobes2", 32'({o_inc_hour, o_inc_min, o_inc_sec}), 0);

      // 2: three INC presses in SET_MIN
      press_mode(2'd1);
      press_mode(2'd2);
      for (int i = 0; i < 3; i++) begin
         i_key_inc = 1'b0;
         step();
         check("min_strobe_on", 32'({o_inc_hour, o_inc_min, o_inc_sec}), 32'b010);
         i_key_inc = 1'b1;
         step();
         check("min_strobe_off", 32'({o_inc_hour, o_inc_min, o_inc_sec}), 0);
      end

      // 3: MODE and INC together in SET_HOUR; MODE wins
      press_mode(2'd3);
      press_mode(2'd0);
      press_mode(2'd1);
      i_key_mode = 1'b0;
      i_key_inc  = 1'b0;
      step();
      check("both_mode", 32'(o_mode), 2);
      check("both_no_hour", 32'(o_inc_hour), 0);
      i_key_mode = 1'b1;
      i_key_inc  = 1'b1;
      step();
      check("both_no_hour_late", 32'(o_inc_hour), 0);

      // 4a: idle timeout in SET_SEC after 10 ticks
      align(1);
      c0 = cyc;
      i_key_mode = 1'b0;
      step();
      check("t4a_enter_sec", 32'(o_mode), 3);
      i_key_mode = 1'b1;
      while (cyc < c0 + 39) step();
      check("t4a_before_mode", 32'(o_mode), 3);
      check("t4a_before_to", 32'(o_timeout), 0);
      step();
      check("t4a_to_pulse", 32'(o_timeout), 1);
      check("t4a_to_mode", 32'(o_mode), 0);
      check("t4a_to_run_en", 32'(o_run_en), 1);
      step();
      check("t4a_to_one_clk", 32'(o_timeout), 0);

      // 4b: INC press after tick 9 restarts the idle count
      press_mode(2'd1);
      press_mode(2'd2);
      align(1);
      c0 = cyc;
      i_key_mode = 1'b0;
      step();
      check("t4b_enter_sec", 32'(o_mode), 3);
      i_key_mode = 1'b1;
      while (cyc < c0 + 36) step();
      i_key_inc = 1'b0;
      step();
      check("t4b_sec_strobe", 32'(o_inc_sec), 1);
      check("t4b_no_to_yet", 32'(o_timeout), 0);
      i_key_inc = 1'b1;
      while (cyc < c0 + 75) step();
      check("t4b_before_mode", 32'(o_mode), 3);
      check("t4b_before_to", 32'(o_timeout), 0);
      step();
      check("t4b_to_pulse", 32'(o_timeout), 1);
      check("t4b_to_mode", 32'(o_mode), 0);

      // 5: INC held 12 ticks in SET_HOUR
      press_mode(2'd1);
      align(1);
      i_key_inc = 1'b0;
      for (int r = 1; r <= 48; r++) begin
         step();
         check($sformatf("t5_hour_r%0d", r), 32'(o_inc_hour), exp_t5(r));
      end
      i_key_inc = 1'b1;
      step();
      i_reset_n = 1'b0;
      repeat (2) step();
      i_reset_n = 1'b1;
      step();
      check("t6_pre_mode", 32'(o_mode), 0);

      // 6: asynchronous reset in the middle of a repeat
      press_mode(2'd1);
      align(1);
      i_key_inc = 1'b0;
      repeat (16) step();
`ifdef KEY_AUTO_REPEAT_EN
      check("t6_hour_before_rst", 32'(o_inc_hour), 1);
`else
      check("t6_hour_before_rst", 32'(o_inc_hour), 0);
`endif
      #1;
      i_reset_n = 1'b0;
      #1;
      check("t6_async_mode", 32'(o_mode), 0);
      check("t6_async_run_en", 32'(o_run_en), 1);
      check("t6_async_hour", 32'(o_inc_hour), 0);
      check("t6_async_to", 32'(o_timeout), 0);
      repeat (2) step();
      i_reset_n = 1'b1;
      step();
      hour_snap = n_hour;
      press_mode(2'd1);
      repeat (32) step();
      check("t6_held_inc_no_strobe", 32'(n_hour - hour_snap), 0);
      check("t6_held_mode", 32'(o_mode), 1);
      i_key_inc = 1'b1;
      step();

      // totals over the whole run
      check("tot_multi_strobe", 32'(n_multi), 0);
      check("tot_run_strobe", 32'(n_run_strobe), 0);
      check("tot_min", 32'(n_min), 3);
      check("tot_sec", 32'(n_sec), 1);
`ifdef KEY_AUTO_REPEAT_EN
      check("tot_hour", 32'(n_hour), 8);
      check("tot_timeout", 32'(n_timeout), 2);
`else
      check("tot_hour", 32'(n_hour), 2);
      check("tot_timeout", 32'(n_timeout), 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
